// File: rtl/writeback_sequencer_pkg.sv
// Shared pipeline definitions for the write-back stage: state encoding, default widths and
// the decoded control-bundle layout shared with the decode stage.
package writeback_sequencer_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned REG_AW_DEF = 4;
    localparam int unsigned ST_W       = 2;

    localparam logic [ST_W-1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [ST_W-1:0] ST_SECOND_ENC = 2'd1;
    localparam logic [ST_W-1:0] ST_HALT_ENC   = 2'd2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_SECOND = ST_SECOND_ENC,
        ST_HALT   = ST_HALT_ENC
    } wb_state_e;

    // Control bundle as produced by decode and carried down to MEM/WB
    typedef struct packed {
        logic reg_write;
        logic write_op2;
        logic halt;
        logic overflow;
    } wb_ctrl_t;

endpackage

// File: rtl/writeback_sequencer.sv
// Write-back sequencer: splits swaps into two register-file writes, suppresses overflowing
// writes and freezes retirement on halt. Optional RETIRE_CNT_EN adds a retired-instruction counter.
module writeback_sequencer
    import writeback_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic              wb_reg_write,
    input  logic              wb_write_op2,
    input  logic              wb_halt,
    input  logic              wb_overflow,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [REG_AW-1:0] wb_rd2,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] wb_data2,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
`ifdef RETIRE_CNT_EN
    output logic [31:0]       retire_cnt,
`endif
    output logic              ovf_flag,
    output logic              halted
);

    wb_state_e         state, state_d;
    wb_ctrl_t          ctrl;
    logic              accept;
    logic              write_ok;
    logic              rf_we_d;
    logic [REG_AW-1:0] rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_d;
    logic              ovf_flag_d;
    logic              halted_d;
    logic [REG_AW-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] data2_q, data2_d;

    assign ctrl     = '{reg_write: wb_reg_write, write_op2: wb_write_op2,
                        halt: wb_halt, overflow: wb_overflow};
    assign wb_ready = (state == ST_IDLE);
    assign accept   = wb_valid & wb_ready;
    assign write_ok = ctrl.reg_write & ~ctrl.overflow;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            ovf_flag <= 1'b0;
            halted   <= 1'b0;
            rd2_q    <= '0;
            data2_q  <= '0;
        end else begin
            state    <= state_d;
            rf_we    <= rf_we_d;
            rf_waddr <= rf_waddr_d;
            rf_wdata <= rf_wdata_d;
            ovf_flag <= ovf_flag_d;
            halted   <= halted_d;
            rd2_q    <= rd2_d;
            data2_q  <= data2_d;
        end
    end

    // Next-state and next-output logic; halted doubles as the pending-halt marker in SECOND
    always_comb begin
        state_d    = state;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr;
        rf_wdata_d = rf_wdata;
        ovf_flag_d = ovf_flag;
        halted_d   = halted;
        rd2_d      = rd2_q;
        data2_d    = data2_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (write_ok) begin
                        rf_we_d    = ~((R0_ZERO != 0) && (wb_rd == '0));
                        rf_waddr_d = wb_rd;
                        rf_wdata_d = wb_data;
                        if (ctrl.write_op2) begin
                            rd2_d   = wb_rd2;
                            data2_d = wb_data2;
                            state_d = ST_SECOND;
                        end
                    end
                    if (ctrl.reg_write && ctrl.overflow) begin
                        ovf_flag_d = 1'b1;
                    end
                    if (ctrl.halt) begin
                        halted_d = 1'b1;
                        if (!(write_ok && ctrl.write_op2)) begin
                            state_d = ST_HALT;
                        end
                    end
                end
            end
            ST_SECOND: begin
                rf_we_d    = ~((R0_ZERO != 0) && (rd2_q == '0));
                rf_waddr_d = rd2_q;
                rf_wdata_d = data2_q;
                state_d    = halted ? ST_HALT : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef RETIRE_CNT_EN
    // Counts accepted instructions; accepts only happen in IDLE so it freezes in HALT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= 32'd0;
        end else if (accept) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed testbench for writeback_sequencer with hand-computed expectations.
// Build with RETIRE_CNT_EN defined to also check the retire counter.
module tb_writeback_sequencer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid;
    logic              wb_ready;
    logic              wb_reg_write;
    logic              wb_write_op2;
    logic              wb_halt;
    logic              wb_overflow;
    logic [REG_AW-1:0] wb_rd;
    logic [REG_AW-1:0] wb_rd2;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] wb_data2;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              ovf_flag;
    logic              halted;
`ifdef RETIRE_CNT_EN
    logic [31:0]       retire_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    writeback_sequencer #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .R0_ZERO(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_reg_write(wb_reg_write),
        .wb_write_op2(wb_write_op2),
        .wb_halt     (wb_halt),
        .wb_overflow (wb_overflow),
        .wb_rd       (wb_rd),
        .wb_rd2      (wb_rd2),
        .wb_data     (wb_data),
        .wb_data2    (wb_data2),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
`ifdef RETIRE_CNT_EN
        .retire_cnt  (retire_cnt),
`endif
        .ovf_flag    (ovf_flag),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        wb_valid     = 1'b0;
        wb_reg_write = 1'b0;
        wb_write_op2 = 1'b0;
        wb_halt      = 1'b0;
        wb_overflow  = 1'b0;
        wb_rd        = '0;
        wb_rd2       = '0;
        wb_data      = '0;
        wb_data2     = '0;
    endtask

    // Present one instruction for one clock, then sample #1 after the edge
    task automatic send(input logic rw, input logic op2, input logic hlt, input logic ovf,
                        input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] d,
                        input logic [REG_AW-1:0] rd2, input logic [DATA_W-1:0] d2);
        wb_valid     = 1'b1;
        wb_reg_write = rw;
        wb_write_op2 = op2;
        wb_halt      = hlt;
        wb_overflow  = ovf;
        wb_rd        = rd;
        wb_data      = d;
        wb_rd2       = rd2;
        wb_data2     = d2;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #1;
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_addr", 64'(rf_waddr), 64'd0);
        check("rst_data", 64'(rf_wdata), 64'd0);
        check("rst_ovf", 64'(ovf_flag), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_ready", 64'(wb_ready), 64'd1);
        step();
        rst = 1'b0;
        step();

        // Plain write
        send(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 16'h1234, 4'd0, 16'h0);
        check("plain_we", 64'(rf_we), 64'd1);
        check("plain_addr", 64'(rf_waddr), 64'd3);
        check("plain_data", 64'(rf_wdata), 64'h1234);
        check("plain_ready", 64'(wb_ready), 64'd1);
        step();
        check("idle_we", 64'(rf_we), 64'd0);
        check("idle_addr_hold", 64'(rf_waddr), 64'd3);
        check("idle_data_hold", 64'(rf_wdata), 64'h1234);

        // Swap: two writes, ready low for exactly one cycle
        send(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 16'h00AA, 4'd5, 16'h0055);
        check("swap1_we", 64'(rf_we), 64'd1);
        check("swap1_addr", 64'(rf_waddr), 64'd2);
        check("swap1_data", 64'(rf_wdata), 64'h00AA);
        check("swap1_ready", 64'(wb_ready), 64'd0);
        step();
        check("swap2_we", 64'(rf_we), 64'd1);
        check("swap2_addr", 64'(rf_waddr), 64'd5);
        check("swap2_data", 64'(rf_wdata), 64'h0055);
        check("swap2_ready", 64'(wb_ready), 64'd1);
        step();
        check("swap_done_we", 64'(rf_we), 64'd0);

        // Swap to the same register: second value wins
        send(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 16'h1111, 4'd6, 16'h2222);
        check("same1_data", 64'(rf_wdata), 64'h1111);
        step();
        check("same2_we", 64'(rf_we), 64'd1);
        check("same2_addr", 64'(rf_waddr), 64'd6);
        check("same2_data", 64'(rf_wdata), 64'h2222);

        // WriteOP2 without RegWrite: no write, no SECOND
        send(1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 16'h7777, 4'd8, 16'h8888);
        check("op2only_we", 64'(rf_we), 64'd0);
        check("op2only_ready", 64'(wb_ready), 64'd1);

        // R0 write suppressed
        send(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'hBEEF, 4'd0, 16'h0);
        check("r0_we", 64'(rf_we), 64'd0);
`ifdef RETIRE_CNT_EN
        check("r0_cnt", 64'(retire_cnt), 64'd5);
`endif

        // Overflowing swap: dropped entirely, sticky flag
        send(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 16'h4444, 4'd9, 16'h9999);
        check("ovf_we", 64'(rf_we), 64'd0);
        check("ovf_flag", 64'(ovf_flag), 64'd1);
        check("ovf_ready", 64'(wb_ready), 64'd1);
        step();
        check("ovf_we2", 64'(rf_we), 64'd0);
        check("ovf_sticky", 64'(ovf_flag), 64'd1);

        // Halt + swap: both writes, then frozen
        send(1'b1, 1'b1, 1'b1, 1'b0, 4'd8, 16'h0808, 4'd9, 16'h0909);
        check("hs1_we", 64'(rf_we), 64'd1);
        check("hs1_addr", 64'(rf_waddr), 64'd8);
        check("hs1_halted", 64'(halted), 64'd1);
        check("hs1_ready", 64'(wb_ready), 64'd0);
        wb_valid     = 1'b1;
        wb_reg_write = 1'b1;
        wb_rd        = 4'd10;
        wb_data      = 16'hAAAA;
        step();
        check("hs2_we", 64'(rf_we), 64'd1);
        check("hs2_addr", 64'(rf_waddr), 64'd9);
        check("hs2_data", 64'(rf_wdata), 64'h0909);
        check("hs2_ready", 64'(wb_ready), 64'd0);
        step();
        check("halt_we", 64'(rf_we), 64'd0);
        check("halt_addr", 64'(rf_waddr), 64'd9);
        check("halt_ready", 64'(wb_ready), 64'd0);
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_ovf", 64'(ovf_flag), 64'd1);
`ifdef RETIRE_CNT_EN
        check("halt_cnt", 64'(retire_cnt), 64'd7);
`endif
        clear_inputs();

        // Reset out of HALT clears everything
        rst = 1'b1;
        #1;
        check("rst2_halted", 64'(halted), 64'd0);
        check("rst2_ovf", 64'(ovf_flag), 64'd0);
        check("rst2_ready", 64'(wb_ready), 64'd1);
        step();
        rst = 1'b0;
        step();

        // Reset mid-swap: second write never issued
        send(1'b1, 1'b1, 1'b0, 1'b0, 4'd11, 16'hB0B0, 4'd12, 16'hC0C0);
        check("ms1_addr", 64'(rf_waddr), 64'd11);
        check("ms1_ready", 64'(wb_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("ms_rst_we", 64'(rf_we), 64'd0);
        check("ms_rst_addr", 64'(rf_waddr), 64'd0);
        check("ms_rst_data", 64'(rf_wdata), 64'd0);
        check("ms_rst_ready", 64'(wb_ready), 64'd1);
`ifdef RETIRE_CNT_EN
        check("ms_rst_cnt", 64'(retire_cnt), 64'd0);
`endif
        @(posedge clk);
        #1;
        check("ms_hold_we", 64'(rf_we), 64'd0);
        check("ms_hold_addr", 64'(rf_waddr), 64'd0);
        rst = 1'b0;
        step();
        check("ms_after_we", 64'(rf_we), 64'd0);
        send(1'b1, 1'b0, 1'b0, 1'b0, 4'd13, 16'h1313, 4'd0, 16'h0);
        check("post_we", 64'(rf_we), 64'd1);
        check("post_addr", 64'(rf_waddr), 64'd13);
        check("post_data", 64'(rf_wdata), 64'h1313);
`ifdef RETIRE_CNT_EN
        check("post_cnt", 64'(retire_cnt), 64'd1);
`endif
        step();
        check("post_idle_we", 64'(rf_we), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
